axi_fault_injector: RTL and testbench
=====================================

Name: axi_fault_injector

Overview:
- Protocol-safe AXI fault and stall injector between an AXI master (e.g. the JTAG-AXI bridge) and the slave/interconnect.
- Generalises the hard "force ready/valid low" timeout stubs:
  - per-channel programmable modes: pass, block, fixed stall, LFSR random backpressure;
  - one-shot SLVERR injection on B and R;
  - per-channel stall statistics.
- Valid/ready gating never drops an asserted valid before its handshake.

Parameters:
- STALL_W, 8, width of fixed-stall cycle count.
- CNT_W, 16, width of per-channel saturating stall counters.
- LFSR_SEED, 16'hACE1, reset value of the 16-bit LFSR; must be nonzero.

Ports:
- clk_axi  in  1  AXI clock.
- ares_axi  in  1  asynchronous active-low reset.
- m_mosi_i  in  s_axi_mosi_t  request bundle from the master.
- m_miso_o  out  s_axi_miso_t  response bundle to the master.
- s_mosi_o  out  s_axi_mosi_t  request bundle to the slave.
- s_miso_i  in  s_axi_miso_t  response bundle from the slave.
- cfg_mode_i  in  [4:0][1:0]  per-channel fault_mode_t, indexed AW=0, W=1, B=2, AR=3, R=4.
- cfg_stall_i  in  STALL_W  stall cycles per beat, used in FIXED mode.
- cfg_thresh_i  in  8  random stall threshold, used in RAND mode.
- cfg_berr_arm_i  in  1  pulse: corrupt the next B response.
- cfg_rerr_arm_i  in  1  pulse: corrupt the next R burst.
- cfg_clr_i  in  1  pulse: clear the stall counters.
- stall_active_o  out  5  channel is stalled this cycle (upstream valid=1, gate closed).
- stall_cnt_o  out  [4:0][CNT_W-1:0]  saturating count of stalled cycles per channel.
- berr_pend_o  out  1  B error injection armed.
- rerr_pend_o  out  1  R error injection armed.

Behaviour:
- Upstream/downstream per channel:
  - AW, W, AR: upstream = master, downstream = slave.
  - B, R: upstream = slave, downstream = master.
- Gating: downstream valid = up_valid & open; upstream ready = dn_ready & open.
- Payload fields pass through combinationally, except resp override (see error injection below).
- Per-channel gate FSM, one axi_fault_gate instance per channel:
  - IDLE: if up_valid=0, stay.
  - IDLE, up_valid=1, mode PASS: open combinationally this cycle → OPEN.
  - IDLE, up_valid=1, FIXED with cfg_stall_i=0: open combinationally this cycle → OPEN.
  - IDLE, up_valid=1, FIXED with N>0: load counter=N → WAIT.
  - IDLE, up_valid=1, RAND: open iff rand slice ≥ cfg_thresh_i; otherwise → WAIT.
  - IDLE, up_valid=1, BLOCK: stay closed in WAIT.
  - WAIT, FIXED: decrement each cycle; at 0, open → OPEN. First possible downstream handshake is N cycles after up_valid rises.
  - WAIT, RAND: re-sample each cycle.
  - WAIT, BLOCK: closed indefinitely.
  - OPEN: open held until downstream handshake, then → IDLE (same cycle).
  - OPEN with no up_valid in the next cycle is impossible by AXI rules; no special handling.
- Mode changes are sampled only in IDLE/WAIT.
  - A channel in OPEN finishes its handshake before a new mode (incl. BLOCK) applies.
  - Changing mode from BLOCK to PASS while in WAIT opens on the next cycle.
- LFSR:
  - 16-bit Galois, taps x^16+x^14+x^13+x^11+1, advances every cycle.
  - Channel i uses bits [7:0] of the LFSR rotated left by 3*i.
  - thresh=0 → never stalls.
- Each gate decides per beat. W and R bursts are stalled beat by beat; wlast/rlast pass unchanged.
- Error injection:
  - berr_pend is set by the arm pulse.
  - At the next master-side B handshake, bresp seen by the master = SLVERR (2'b10); pend clears on that handshake.
  - rerr_pend forces rresp=SLVERR on every R beat of the next burst whose first beat handshakes while armed; clears on the rlast handshake.
  - An arm pulse arriving while pend=1 is ignored.
  - An arm pulse coincident with a handshake applies to the following transaction.
  - bid/rid and data are never altered.
- Counters:
  - stall_cnt_o[i] increments when stall_active_o[i]=1 and saturates at all-ones.
  - cfg_clr_i has priority over increment.
- Reset, asynchronous, active-low:
  - All gates IDLE, counters 0, LFSR=LFSR_SEED, pends 0, stall_active_o=0.
  - Assertion mid-stall or mid-burst aborts silently. Both sides are assumed reset together.

Decomposition:
- jtag_axi_pkg:
  - fault_mode_t enum (PASS=0, BLOCK=1, FIXED=2, RAND=3).
  - Channel index constants CH_AW..CH_R.
  - LFSR tap constant.
- Sub-module axi_fault_gate (FSM + stall counter + stats counter), instantiated 5x.
- LFSR and error-injection logic live in the top.

Test Plan:
- All PASS, 8 single writes + 8 reads → zero added latency; all stall_cnt_o=0.
- AW FIXED, cfg_stall_i=3 → s awvalid rises exactly 3 cycles after m awvalid; stall_cnt_o[0]=3 per write.
- W BLOCK for 50 cycles, then PASS → no W handshake during block; stall_cnt_o[1]=50; write completes with OKAY afterward.
- RAND, thresh=0 → no stalls. RAND, thresh=128, 1000 R beats → stall ratio 40–60%; awvalid/wvalid/rvalid never deassert before handshake (assertion checker).
- berr arm, then 2 writes → first bresp=SLVERR, second OKAY. rerr arm with 4-beat read → all 4 rresp=SLVERR; next read OKAY.
- ares_axi low mid FIXED stall → after release, gates IDLE, counters 0, next transaction behaves per current cfg.

Source files
------------

// File: rtl/jtag_axi_pkg.sv
// Shared types for the JTAG-AXI path: AXI request/response bundles, the
// fault-injector channel indices, mode encoding and LFSR helpers.
package jtag_axi_pkg;

   localparam int ID_W   = 4;
   localparam int ADDR_W = 32;
   localparam int DATA_W = 32;

   // Channel order used by every per-channel vector of the fault injector.
   localparam int CH_AW  = 0;
   localparam int CH_W   = 1;
   localparam int CH_B   = 2;
   localparam int CH_AR  = 3;
   localparam int CH_R   = 4;
   localparam int NUM_CH = 5;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   // Right-shifting Galois form of x^16 + x^14 + x^13 + x^11 + 1.
   localparam logic [15:0] LFSR_TAPS = 16'hB400;

   typedef enum logic [1:0] {
      PASS  = 2'd0,
      BLOCK = 2'd1,
      FIXED = 2'd2,
      RAND  = 2'd3
   } fault_mode_t;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_OPEN = 2'd2
   } gate_state_t;

   // Master -> slave direction of all five channels.
   typedef struct packed {
      logic [ID_W-1:0]     aw_id;
      logic [ADDR_W-1:0]   aw_addr;
      logic [7:0]          aw_len;
      logic [2:0]          aw_size;
      logic [1:0]          aw_burst;
      logic                aw_valid;
      logic [DATA_W-1:0]   w_data;
      logic [DATA_W/8-1:0] w_strb;
      logic                w_last;
      logic                w_valid;
      logic                b_ready;
      logic [ID_W-1:0]     ar_id;
      logic [ADDR_W-1:0]   ar_addr;
      logic [7:0]          ar_len;
      logic [2:0]          ar_size;
      logic [1:0]          ar_burst;
      logic                ar_valid;
      logic                r_ready;
   } s_axi_mosi_t;

   // Slave -> master direction of all five channels.
   typedef struct packed {
      logic                aw_ready;
      logic                w_ready;
      logic [ID_W-1:0]     b_id;
      logic [1:0]          b_resp;
      logic                b_valid;
      logic                ar_ready;
      logic [ID_W-1:0]     r_id;
      logic [DATA_W-1:0]   r_data;
      logic [1:0]          r_resp;
      logic                r_last;
      logic                r_valid;
   } s_axi_miso_t;

   // Random byte for channel ch: LFSR rotated left by 3*ch, low 8 bits.
   // Rotating decorrelates the channels while sharing a single LFSR.
   function automatic logic [7:0] lfsr_slice(input logic [15:0] lfsr,
                                             input int unsigned ch);
      logic [15:0] rot;
      rot = (lfsr << (3 * ch)) | (lfsr >> (16 - 3 * ch));
      return rot[7:0];
   endfunction

endpackage

// File: rtl/axi_fault_injector_gate.sv
// axi_fault_gate: valid/ready gate for one AXI channel.
//   up_valid / up_ready   : handshake toward the channel's source
//   dn_valid / dn_ready   : handshake toward the channel's sink
//   mode, stall_cycles,
//   thresh, rand_byte     : fault configuration (mode sampled in IDLE/WAIT)
//   cnt_clr               : clear the stall statistic
//   stall_active          : source is presenting a beat that the gate holds
//   stall_cnt             : saturating count of stall_active cycles
// Once the gate opens it stays open until the beat handshakes, so a valid
// that has been shown downstream is never withdrawn.
module axi_fault_gate
   import jtag_axi_pkg::*;
#(
   parameter int STALL_W = 8,
   parameter int CNT_W   = 16
) (
   input  logic               clk_axi,
   input  logic               ares_axi,
   input  fault_mode_t        mode,
   input  logic [STALL_W-1:0] stall_cycles,
   input  logic [7:0]         thresh,
   input  logic [7:0]         rand_byte,
   input  logic               cnt_clr,
   input  logic               up_valid,
   input  logic               dn_ready,
   output logic               dn_valid,
   output logic               up_ready,
   output logic               stall_active,
   output logic [CNT_W-1:0]   stall_cnt
);

   gate_state_t        state_q, state_d;
   logic [STALL_W-1:0] wait_q, wait_d;
   logic               gate_open;
   logic               rand_pass;

   assign rand_pass = (rand_byte >= thresh);

   always_comb begin
      // NOTE: every output of this block is defaulted first so no path
      // leaves a variable unassigned and infers a latch.
      state_d   = state_q;
      wait_d    = wait_q;
      gate_open = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (up_valid) begin
               case (mode)
                  PASS:  gate_open = 1'b1;
                  FIXED: begin
                     if (stall_cycles == '0) begin
                        gate_open = 1'b1;
                     end else begin
                        // This cycle is the first stall, so N-1 remain.
                        wait_d  = stall_cycles - 1'b1;
                        state_d = S_WAIT;
                     end
                  end
                  RAND: begin
                     if (rand_pass) gate_open = 1'b1;
                     else           state_d   = S_WAIT;
                  end
                  default: state_d = S_WAIT;   // BLOCK
               endcase
            end
         end
         S_WAIT: begin
            case (mode)
               PASS:  gate_open = 1'b1;
               FIXED: begin
                  if (wait_q == '0) gate_open = 1'b1;
                  else              wait_d    = wait_q - 1'b1;
               end
               RAND:    gate_open = rand_pass;
               default: gate_open = 1'b0;      // BLOCK
            endcase
         end
         S_OPEN:  gate_open = 1'b1;
         default: state_d = S_IDLE;
      endcase
      // An open gate either completes the beat now or holds open for it.
      if (gate_open) begin
         state_d = (up_valid && dn_ready) ? S_IDLE : S_OPEN;
      end
   end

   assign dn_valid     = up_valid & gate_open;
   assign up_ready     = dn_ready & gate_open;
   assign stall_active = up_valid & ~gate_open;

   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples pre-edge values regardless of evaluation order.
   always_ff @(posedge clk_axi or negedge ares_axi) begin
      if (!ares_axi) begin
         state_q   <= S_IDLE;
         wait_q    <= '0;
         stall_cnt <= '0;
      end else begin
         state_q <= state_d;
         wait_q  <= wait_d;
         if (cnt_clr) begin
            stall_cnt <= '0;
         end else if (stall_active && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/axi_fault_injector.sv
// axi_fault_injector: protocol-safe stall/fault injector between an AXI
// master and its slave.
//   m_mosi_i / m_miso_o : master-side request in, response out
//   s_mosi_o / s_miso_i : slave-side request out, response in
//   cfg_mode_i          : per-channel fault_mode_t (AW,W,B,AR,R = 0..4)
//   cfg_stall_i         : FIXED-mode stall cycles per beat
//   cfg_thresh_i        : RAND-mode threshold (beat passes if rand >= thresh)
//   cfg_berr_arm_i      : pulse, next B response returns SLVERR
//   cfg_rerr_arm_i      : pulse, next R burst returns SLVERR on every beat
//   cfg_clr_i           : pulse, clear stall counters
//   stall_active_o      : per-channel stall this cycle
//   stall_cnt_o         : per-channel saturating stall counters
//   berr_pend_o/rerr_pend_o : error injection armed
module axi_fault_injector
   import jtag_axi_pkg::*;
#(
   parameter int          STALL_W   = 8,
   parameter int          CNT_W     = 16,
   parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
   input  logic                         clk_axi,
   input  logic                         ares_axi,
   input  s_axi_mosi_t                  m_mosi_i,
   output s_axi_miso_t                  m_miso_o,
   output s_axi_mosi_t                  s_mosi_o,
   input  s_axi_miso_t                  s_miso_i,
   input  logic [NUM_CH-1:0][1:0]       cfg_mode_i,
   input  logic [STALL_W-1:0]           cfg_stall_i,
   input  logic [7:0]                   cfg_thresh_i,
   input  logic                         cfg_berr_arm_i,
   input  logic                         cfg_rerr_arm_i,
   input  logic                         cfg_clr_i,
   output logic [NUM_CH-1:0]            stall_active_o,
   output logic [NUM_CH-1:0][CNT_W-1:0] stall_cnt_o,
   output logic                         berr_pend_o,
   output logic                         rerr_pend_o
);

   logic [15:0]       lfsr_q;
   logic [NUM_CH-1:0] up_valid, dn_ready, dn_valid, up_ready;
   logic              berr_pend_q, rerr_pend_q;
   logic              rerr_lock_q;   // corrupted burst is in flight
   logic              r_mid_q;       // master-side R burst is in flight
   logic              b_hs, r_hs, r_corrupt;

   // B and R flow slave -> master; the rest flow master -> slave.
   assign up_valid[CH_AW] = m_mosi_i.aw_valid;
   assign up_valid[CH_W]  = m_mosi_i.w_valid;
   assign up_valid[CH_B]  = s_miso_i.b_valid;
   assign up_valid[CH_AR] = m_mosi_i.ar_valid;
   assign up_valid[CH_R]  = s_miso_i.r_valid;
   assign dn_ready[CH_AW] = s_miso_i.aw_ready;
   assign dn_ready[CH_W]  = s_miso_i.w_ready;
   assign dn_ready[CH_B]  = m_mosi_i.b_ready;
   assign dn_ready[CH_AR] = s_miso_i.ar_ready;
   assign dn_ready[CH_R]  = m_mosi_i.r_ready;

   for (genvar g = 0; g < NUM_CH; g++) begin : g_gate
      axi_fault_gate #(
         .STALL_W (STALL_W),
         .CNT_W   (CNT_W)
      ) u_gate (
         .clk_axi      (clk_axi),
         .ares_axi     (ares_axi),
         .mode         (fault_mode_t'(cfg_mode_i[g])),
         .stall_cycles (cfg_stall_i),
         .thresh       (cfg_thresh_i),
         .rand_byte    (lfsr_slice(lfsr_q, g)),
         .cnt_clr      (cfg_clr_i),
         .up_valid     (up_valid[g]),
         .dn_ready     (dn_ready[g]),
         .dn_valid     (dn_valid[g]),
         .up_ready     (up_ready[g]),
         .stall_active (stall_active_o[g]),
         .stall_cnt    (stall_cnt_o[g])
      );
   end

   assign b_hs = dn_valid[CH_B] & m_mosi_i.b_ready;
   assign r_hs = dn_valid[CH_R] & m_mosi_i.r_ready;
   // A burst is corrupted only if its first beat arrives while armed.
   assign r_corrupt = rerr_pend_q & (rerr_lock_q | ~r_mid_q);

   always_ff @(posedge clk_axi or negedge ares_axi) begin
      if (!ares_axi) begin
         lfsr_q      <= LFSR_SEED;
         berr_pend_q <= 1'b0;
         rerr_pend_q <= 1'b0;
         rerr_lock_q <= 1'b0;
         r_mid_q     <= 1'b0;
      end else begin
         lfsr_q <= {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_TAPS : 16'h0000);

         // Arm pulses while already pending are dropped.
         if (berr_pend_q) begin
            if (b_hs) berr_pend_q <= 1'b0;
         end else if (cfg_berr_arm_i) begin
            berr_pend_q <= 1'b1;
         end

         if (rerr_pend_q) begin
            if (r_hs && r_corrupt) begin
               rerr_lock_q <= ~m_miso_o.r_last;
               if (m_miso_o.r_last) rerr_pend_q <= 1'b0;
            end
         end else if (cfg_rerr_arm_i) begin
            rerr_pend_q <= 1'b1;
         end

         if (r_hs) r_mid_q <= ~m_miso_o.r_last;
      end
   end

   always_comb begin
      s_mosi_o          = m_mosi_i;
      s_mosi_o.aw_valid = dn_valid[CH_AW];
      s_mosi_o.w_valid  = dn_valid[CH_W];
      s_mosi_o.ar_valid = dn_valid[CH_AR];
      s_mosi_o.b_ready  = up_ready[CH_B];
      s_mosi_o.r_ready  = up_ready[CH_R];

      m_miso_o          = s_miso_i;
      m_miso_o.aw_ready = up_ready[CH_AW];
      m_miso_o.w_ready  = up_ready[CH_W];
      m_miso_o.ar_ready = up_ready[CH_AR];
      m_miso_o.b_valid  = dn_valid[CH_B];
      m_miso_o.r_valid  = dn_valid[CH_R];
      if (berr_pend_q) m_miso_o.b_resp = RESP_SLVERR;
      if (r_corrupt)   m_miso_o.r_resp = RESP_SLVERR;
   end

   assign berr_pend_o = berr_pend_q;
   assign rerr_pend_o = rerr_pend_q;

endmodule

// File: tb/tb_axi_fault_injector.sv
// Self-checking bench for axi_fault_injector: a bench-side master driver,
// a queue-based slave model and expectations taken from the block's rules.
module tb_axi_fault_injector;
   import jtag_axi_pkg::*;

   localparam int STALL_W = 8;
   localparam int CNT_W   = 16;
   localparam int TMO     = 3000;

   logic clk_axi  = 1'b0;
   logic ares_axi = 1'b0;
   always #5 clk_axi = ~clk_axi;

   s_axi_mosi_t                  m_mosi, s_mosi;
   s_axi_miso_t                  m_miso, s_miso;
   logic [NUM_CH-1:0][1:0]       cfg_mode;
   logic [STALL_W-1:0]           cfg_stall;
   logic [7:0]                   cfg_thresh;
   logic                         cfg_berr_arm, cfg_rerr_arm, cfg_clr;
   logic [NUM_CH-1:0]            stall_active;
   logic [NUM_CH-1:0][CNT_W-1:0] stall_cnt;
   logic                         berr_pend, rerr_pend;

   int n_tests = 0;
   int n_fail  = 0;
   int viol    = 0;

   axi_fault_injector #(.STALL_W(STALL_W), .CNT_W(CNT_W), .LFSR_SEED(16'hACE1)) dut (
      .clk_axi        (clk_axi),
      .ares_axi       (ares_axi),
      .m_mosi_i       (m_mosi),
      .m_miso_o       (m_miso),
      .s_mosi_o       (s_mosi),
      .s_miso_i       (s_miso),
      .cfg_mode_i     (cfg_mode),
      .cfg_stall_i    (cfg_stall),
      .cfg_thresh_i   (cfg_thresh),
      .cfg_berr_arm_i (cfg_berr_arm),
      .cfg_rerr_arm_i (cfg_rerr_arm),
      .cfg_clr_i      (cfg_clr),
      .stall_active_o (stall_active),
      .stall_cnt_o    (stall_cnt),
      .berr_pend_o    (berr_pend),
      .rerr_pend_o    (rerr_pend)
   );

   // Read data the slave returns for a given address and beat.
   function automatic logic [31:0] rdata_f(input logic [31:0] addr, input int beat);
      return addr ^ (32'h0101_0101 * beat) ^ 32'h5A5A_0000;
   endfunction

   // ---------------- slave model ----------------
   typedef struct packed {
      logic [ID_W-1:0] id;
      logic [31:0]     addr;
      logic [7:0]      len;
   } ar_req_t;

   logic [ID_W-1:0] slv_awq[$];
   logic [31:0]     slv_wq[$];
   ar_req_t         slv_arq[$];
   logic [31:0]     slv_last_data;

   initial begin : slave
      bit      aw_hs, w_hs, b_hs, ar_hs, r_hs;
      ar_req_t ar_smp, cur;
      logic [ID_W-1:0] aw_id_smp;
      logic [31:0]     w_smp;
      int      r_beat;
      s_miso        = '0;
      slv_last_data = '0;
      r_beat        = 0;
      cur           = '0;
      forever begin
         @(negedge clk_axi);
         aw_hs     = s_mosi.aw_valid && s_miso.aw_ready;
         w_hs      = s_mosi.w_valid && s_miso.w_ready;
         b_hs      = s_miso.b_valid && s_mosi.b_ready;
         ar_hs     = s_mosi.ar_valid && s_miso.ar_ready;
         r_hs      = s_miso.r_valid && s_mosi.r_ready;
         aw_id_smp = s_mosi.aw_id;
         w_smp     = s_mosi.w_data;
         ar_smp    = '{id: s_mosi.ar_id, addr: s_mosi.ar_addr, len: s_mosi.ar_len};
         @(posedge clk_axi);
         #1;
         if (!ares_axi) begin
            slv_awq.delete();
            slv_wq.delete();
            slv_arq.delete();
            s_miso = '0;
         end else begin
            s_miso.aw_ready = 1'b1;
            s_miso.w_ready  = 1'b1;
            s_miso.ar_ready = 1'b1;
            if (aw_hs) slv_awq.push_back(aw_id_smp);
            if (w_hs) begin
               slv_wq.push_back(w_smp);
               slv_last_data = w_smp;
            end
            if (ar_hs) slv_arq.push_back(ar_smp);
            if (b_hs) s_miso.b_valid = 1'b0;
            if (!s_miso.b_valid && slv_awq.size() > 0 && slv_wq.size() > 0) begin
               s_miso.b_id    = slv_awq.pop_front();
               void'(slv_wq.pop_front());
               s_miso.b_resp  = RESP_OKAY;
               s_miso.b_valid = 1'b1;
            end
            if (r_hs) begin
               if (s_miso.r_last) begin
                  s_miso.r_valid = 1'b0;
               end else begin
                  r_beat++;
                  s_miso.r_data = rdata_f(cur.addr, r_beat);
                  s_miso.r_last = (r_beat == int'(cur.len));
               end
            end
            if (!s_miso.r_valid && slv_arq.size() > 0) begin
               cur            = slv_arq.pop_front();
               r_beat         = 0;
               s_miso.r_id    = cur.id;
               s_miso.r_data  = rdata_f(cur.addr, 0);
               s_miso.r_last  = (cur.len == 8'd0);
               s_miso.r_resp  = RESP_OKAY;
               s_miso.r_valid = 1'b1;
            end
         end
      end
   end

   // Valid must never fall before its handshake (slave-side AW/W, master-side R).
   initial begin : valid_checker
      logic [2:0] pv, ph, v, h;
      bit         pr;
      pv = '0;
      ph = '0;
      pr = 1'b0;
      forever begin
         @(negedge clk_axi);
         v = {m_miso.r_valid, s_mosi.w_valid, s_mosi.aw_valid};
         h = v & {m_mosi.r_ready, s_miso.w_ready, s_miso.aw_ready};
         if (ares_axi && pr && ((pv & ~ph & ~v) != 3'b000)) begin
            viol++;
            $display("FAIL valid_stable: dropped {r,w,aw}=%b at %0t", pv & ~ph & ~v, $time);
         end
         pv = v;
         ph = h;
         pr = ares_axi;
      end
   end

   // ---------------- master driver ----------------
   task automatic sync();
      @(posedge clk_axi);
      #1;
   endtask

   task automatic set_all(input fault_mode_t m);
      for (int i = 0; i < NUM_CH; i++) cfg_mode[i] = m;
   endtask

   task automatic pulse_clr();
      cfg_clr = 1'b1;
      sync();
      cfg_clr = 1'b0;
   endtask

   // Single-beat write. pass_after >= 0 switches W to PASS at that cycle.
   task automatic do_write(input logic [ID_W-1:0] id, input logic [31:0] addr,
                           input logic [31:0] data, input int pass_after,
                           output int aw_lat, output int w_lat,
                           output logic [1:0] bresp, output logic [ID_W-1:0] bid,
                           output bit ok);
      bit aw_hs, w_hs, b_done;
      int cyc;
      m_mosi.aw_id    = id;
      m_mosi.aw_addr  = addr;
      m_mosi.aw_len   = 8'd0;
      m_mosi.aw_size  = 3'd2;
      m_mosi.aw_burst = 2'b01;
      m_mosi.w_data   = data;
      m_mosi.w_strb   = '1;
      m_mosi.w_last   = 1'b1;
      m_mosi.aw_valid = 1'b1;
      m_mosi.w_valid  = 1'b1;
      m_mosi.b_ready  = 1'b1;
      aw_lat = -1;
      w_lat  = -1;
      bresp  = 2'bxx;
      bid    = 'x;
      b_done = 1'b0;
      cyc    = 0;
      while (!b_done && cyc < TMO) begin
         @(negedge clk_axi);
         if (aw_lat < 0 && s_mosi.aw_valid) aw_lat = cyc;
         if (w_lat < 0 && s_mosi.w_valid) w_lat = cyc;
         aw_hs = m_mosi.aw_valid && m_miso.aw_ready;
         w_hs  = m_mosi.w_valid && m_miso.w_ready;
         if (m_miso.b_valid && m_mosi.b_ready) begin
            b_done = 1'b1;
            bresp  = m_miso.b_resp;
            bid    = m_miso.b_id;
         end
         sync();
         if (aw_hs) m_mosi.aw_valid = 1'b0;
         if (w_hs)  m_mosi.w_valid  = 1'b0;
         cyc++;
         if (cyc == pass_after) cfg_mode[CH_W] = PASS;
      end
      m_mosi.aw_valid = 1'b0;
      m_mosi.w_valid  = 1'b0;
      m_mosi.b_ready  = 1'b0;
      ok = b_done;
   endtask

   task automatic do_read(input logic [ID_W-1:0] id, input logic [31:0] addr,
                          input logic [7:0] len, output int ar_lat, output int beats,
                          output int nerr, output int nbad, output bit ok);
      bit ar_hs, done;
      int cyc;
      m_mosi.ar_id    = id;
      m_mosi.ar_addr  = addr;
      m_mosi.ar_len   = len;
      m_mosi.ar_size  = 3'd2;
      m_mosi.ar_burst = 2'b01;
      m_mosi.ar_valid = 1'b1;
      m_mosi.r_ready  = 1'b1;
      ar_lat = -1;
      beats  = 0;
      nerr   = 0;
      nbad   = 0;
      done   = 1'b0;
      cyc    = 0;
      while (!done && cyc < TMO) begin
         @(negedge clk_axi);
         if (ar_lat < 0 && s_mosi.ar_valid) ar_lat = cyc;
         ar_hs = m_mosi.ar_valid && m_miso.ar_ready;
         if (m_miso.r_valid && m_mosi.r_ready) begin
            if (m_miso.r_resp == RESP_SLVERR) nerr++;
            if (m_miso.r_data !== rdata_f(addr, beats) || m_miso.r_id !== id ||
                m_miso.r_last !== (beats == int'(len))) nbad++;
            if (m_miso.r_last) done = 1'b1;
            beats++;
         end
         sync();
         if (ar_hs) m_mosi.ar_valid = 1'b0;
         cyc++;
      end
      m_mosi.ar_valid = 1'b0;
      m_mosi.r_ready  = 1'b0;
      ok = done;
   endtask

   int               lat_a, lat_w, beats, nerr, nbad;
   logic [1:0]       bresp;
   logic [ID_W-1:0]  bid;
   bit               ok;

   // ---------------- tests ----------------
   task automatic test_reset();
      ares_axi = 1'b0;
      repeat (3) @(posedge clk_axi);
      @(negedge clk_axi);
      n_tests++;
      if (stall_cnt !== '0 || stall_active !== '0 || berr_pend !== 1'b0 || rerr_pend !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_state: cnt=%h act=%b berr=%b rerr=%b, want all zero",
                  stall_cnt, stall_active, berr_pend, rerr_pend);
      end
      n_tests++;
      if (s_mosi.aw_valid !== 1'b0 || m_miso.r_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_valids: s_awvalid=%b m_rvalid=%b, want 0", s_mosi.aw_valid, m_miso.r_valid);
      end
      sync();
      ares_axi = 1'b1;
      repeat (2) sync();
   endtask

   task automatic test_pass();
      logic [ID_W-1:0] id;
      logic [31:0]     a, d;
      logic [7:0]      len;
      set_all(PASS);
      pulse_clr();
      for (int i = 0; i < 8; i++) begin
         id = ID_W'($urandom_range(15));
         a  = $urandom & 32'hFFFF_FFFC;
         d  = $urandom;
         do_write(id, a, d, -1, lat_a, lat_w, bresp, bid, ok);
         n_tests++;
         if (!ok || lat_a != 0 || lat_w != 0 || bresp !== RESP_OKAY || bid !== id || slv_last_data !== d) begin
            n_fail++;
            $display("FAIL pass_write%0d: ok=%0d aw_lat=%0d w_lat=%0d bresp=%b bid=%h data=%h, want 1 0 0 00 %h %h",
                     i, ok, lat_a, lat_w, bresp, bid, slv_last_data, id, d);
         end
      end
      for (int i = 0; i < 8; i++) begin
         id  = ID_W'($urandom_range(15));
         a   = $urandom & 32'hFFFF_FFFC;
         len = 8'($urandom_range(7));
         do_read(id, a, len, lat_a, beats, nerr, nbad, ok);
         n_tests++;
         if (!ok || lat_a != 0 || beats != int'(len) + 1 || nerr != 0 || nbad != 0) begin
            n_fail++;
            $display("FAIL pass_read%0d: ok=%0d ar_lat=%0d beats=%0d err=%0d bad=%0d, want 1 0 %0d 0 0",
                     i, ok, lat_a, beats, nerr, nbad, int'(len) + 1);
         end
      end
      n_tests++;
      if (stall_cnt !== '0) begin
         n_fail++;
         $display("FAIL pass_stall_cnt: got %h, want 0", stall_cnt);
      end
   endtask

   task automatic test_fixed();
      set_all(PASS);
      cfg_mode[CH_AW] = FIXED;
      cfg_stall = 8'd3;
      pulse_clr();
      for (int i = 1; i <= 3; i++) begin
         do_write(ID_W'(i), 32'h100 * i, $urandom, -1, lat_a, lat_w, bresp, bid, ok);
         n_tests++;
         if (!ok || lat_a != 3 || bresp !== RESP_OKAY) begin
            n_fail++;
            $display("FAIL fixed_latency%0d: ok=%0d aw_lat=%0d bresp=%b, want 1 3 00", i, ok, lat_a, bresp);
         end
         n_tests++;
         if (stall_cnt[CH_AW] !== CNT_W'(3 * i)) begin
            n_fail++;
            $display("FAIL fixed_cnt%0d: got %0d, want %0d", i, stall_cnt[CH_AW], 3 * i);
         end
      end
      // FIXED with zero stall opens immediately.
      cfg_stall = 8'd0;
      do_write(4'h7, 32'h400, 32'hCAFE_F00D, -1, lat_a, lat_w, bresp, bid, ok);
      n_tests++;
      if (!ok || lat_a != 0) begin
         n_fail++;
         $display("FAIL fixed_zero: ok=%0d aw_lat=%0d, want 1 0", ok, lat_a);
      end
   endtask

   task automatic test_block();
      set_all(PASS);
      cfg_mode[CH_W] = BLOCK;
      pulse_clr();
      do_write(4'h3, 32'h2000, 32'h1234_5678, 50, lat_a, lat_w, bresp, bid, ok);
      n_tests++;
      if (!ok || lat_w != 50 || bresp !== RESP_OKAY || slv_last_data !== 32'h1234_5678) begin
         n_fail++;
         $display("FAIL block_write: ok=%0d w_lat=%0d bresp=%b data=%h, want 1 50 00 12345678",
                  ok, lat_w, bresp, slv_last_data);
      end
      n_tests++;
      if (stall_cnt[CH_W] !== CNT_W'(50) || stall_cnt[CH_AW] !== '0) begin
         n_fail++;
         $display("FAIL block_cnt: w=%0d aw=%0d, want 50 0", stall_cnt[CH_W], stall_cnt[CH_AW]);
      end
   endtask

   task automatic test_rand();
      int stalls, total_beats, pct;
      set_all(RAND);
      cfg_thresh = 8'd0;
      pulse_clr();
      for (int i = 0; i < 4; i++) begin
         do_write(ID_W'(i), 32'h3000 + 32'(i) * 4, $urandom, -1, lat_a, lat_w, bresp, bid, ok);
         do_read(ID_W'(i), 32'h3000 + 32'(i) * 64, 8'd3, lat_a, beats, nerr, nbad, ok);
      end
      n_tests++;
      if (stall_cnt !== '0) begin
         n_fail++;
         $display("FAIL rand_thresh0: cnt=%h, want 0", stall_cnt);
      end
      set_all(PASS);
      cfg_mode[CH_R] = RAND;
      cfg_thresh = 8'd128;
      pulse_clr();
      total_beats = 0;
      for (int i = 0; i < 63; i++) begin
         do_read(ID_W'(i), 32'h1_0000 + 32'(i) * 64, 8'd15, lat_a, beats, nerr, nbad, ok);
         total_beats += beats;
         n_tests++;
         if (!ok || beats != 16 || nbad != 0 || nerr != 0) begin
            n_fail++;
            $display("FAIL rand_read%0d: ok=%0d beats=%0d bad=%0d err=%0d, want 1 16 0 0",
                     i, ok, beats, nbad, nerr);
         end
      end
      stalls = int'(stall_cnt[CH_R]);
      pct = (stalls * 100) / (stalls + total_beats);
      n_tests++;
      if (pct < 40 || pct > 60) begin
         n_fail++;
         $display("FAIL rand_ratio: %0d%% (%0d stalls, %0d beats), want 40..60", pct, stalls, total_beats);
      end
   endtask

   // All channels random-gated with a random threshold; data must survive.
   task automatic test_stress();
      logic [31:0] d, a;
      set_all(RAND);
      cfg_thresh = 8'($urandom_range(200, 30));
      for (int i = 0; i < 12; i++) begin
         d = $urandom;
         a = $urandom & 32'h0FFF_FFFC;
         do_write(ID_W'(i), a, d, -1, lat_a, lat_w, bresp, bid, ok);
         n_tests++;
         if (!ok || bresp !== RESP_OKAY || bid !== ID_W'(i) || slv_last_data !== d) begin
            n_fail++;
            $display("FAIL stress_write%0d: ok=%0d bresp=%b bid=%h data=%h, want 1 00 %h %h",
                     i, ok, bresp, bid, slv_last_data, ID_W'(i), d);
         end
         do_read(ID_W'(i), a, 8'($urandom_range(5)), lat_a, beats, nerr, nbad, ok);
         n_tests++;
         if (!ok || nbad != 0 || nerr != 0) begin
            n_fail++;
            $display("FAIL stress_read%0d: ok=%0d bad=%0d err=%0d, want 1 0 0", i, ok, nbad, nerr);
         end
      end
   endtask

   task automatic test_errors();
      set_all(PASS);
      cfg_berr_arm = 1'b1;
      sync();
      cfg_berr_arm = 1'b0;
      n_tests++;
      if (berr_pend !== 1'b1) begin
         n_fail++;
         $display("FAIL berr_armed: got %b, want 1", berr_pend);
      end
      do_write(4'h5, 32'h500, 32'hAAAA_5555, -1, lat_a, lat_w, bresp, bid, ok);
      n_tests++;
      if (!ok || bresp !== RESP_SLVERR || bid !== 4'h5 || berr_pend !== 1'b0) begin
         n_fail++;
         $display("FAIL berr_first: ok=%0d bresp=%b bid=%h pend=%b, want 1 10 5 0", ok, bresp, bid, berr_pend);
      end
      do_write(4'h6, 32'h504, 32'h5555_AAAA, -1, lat_a, lat_w, bresp, bid, ok);
      n_tests++;
      if (!ok || bresp !== RESP_OKAY) begin
         n_fail++;
         $display("FAIL berr_second: ok=%0d bresp=%b, want 1 00", ok, bresp);
      end
      cfg_rerr_arm = 1'b1;
      sync();
      cfg_rerr_arm = 1'b0;
      do_read(4'h9, 32'h800, 8'd3, lat_a, beats, nerr, nbad, ok);
      n_tests++;
      if (!ok || beats != 4 || nerr != 4 || nbad != 0 || rerr_pend !== 1'b0) begin
         n_fail++;
         $display("FAIL rerr_burst: ok=%0d beats=%0d slverr=%0d bad=%0d pend=%b, want 1 4 4 0 0",
                  ok, beats, nerr, nbad, rerr_pend);
      end
      do_read(4'hA, 32'h900, 8'd3, lat_a, beats, nerr, nbad, ok);
      n_tests++;
      if (!ok || beats != 4 || nerr != 0 || nbad != 0) begin
         n_fail++;
         $display("FAIL rerr_next: ok=%0d beats=%0d slverr=%0d bad=%0d, want 1 4 0 0", ok, beats, nerr, nbad);
      end
   endtask

   task automatic test_reset_mid();
      set_all(PASS);
      cfg_mode[CH_AW] = FIXED;
      cfg_stall = 8'd10;
      pulse_clr();
      cfg_berr_arm = 1'b1;
      sync();
      cfg_berr_arm = 1'b0;
      m_mosi.aw_id    = 4'h2;
      m_mosi.aw_addr  = 32'hC00;
      m_mosi.aw_valid = 1'b1;
      repeat (4) sync();
      @(negedge clk_axi);
      n_tests++;
      if (stall_active[CH_AW] !== 1'b1 || stall_cnt[CH_AW] !== CNT_W'(4)) begin
         n_fail++;
         $display("FAIL mid_stall: act=%b cnt=%0d, want 1 4", stall_active[CH_AW], stall_cnt[CH_AW]);
      end
      sync();
      ares_axi        = 1'b0;
      m_mosi.aw_valid = 1'b0;
      repeat (2) sync();
      @(negedge clk_axi);
      n_tests++;
      if (stall_cnt !== '0 || stall_active !== '0 || berr_pend !== 1'b0 || s_mosi.aw_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL mid_reset: cnt=%h act=%b berr=%b s_awvalid=%b, want all zero",
                  stall_cnt, stall_active, berr_pend, s_mosi.aw_valid);
      end
      sync();
      ares_axi  = 1'b1;
      cfg_stall = 8'd4;
      repeat (2) sync();
      do_write(4'h2, 32'hC00, 32'h0BAD_BEEF, -1, lat_a, lat_w, bresp, bid, ok);
      n_tests++;
      if (!ok || lat_a != 4 || bresp !== RESP_OKAY || stall_cnt[CH_AW] !== CNT_W'(4)) begin
         n_fail++;
         $display("FAIL after_reset: ok=%0d aw_lat=%0d bresp=%b cnt=%0d, want 1 4 00 4",
                  ok, lat_a, bresp, stall_cnt[CH_AW]);
      end
   endtask

   task automatic test_protocol();
      n_tests++;
      if (viol != 0) begin
         n_fail++;
         $display("FAIL valid_protocol: %0d early valid drops, want 0", viol);
      end
   endtask

   initial begin
      m_mosi       = '0;
      cfg_mode     = '0;
      cfg_stall    = '0;
      cfg_thresh   = '0;
      cfg_berr_arm = 1'b0;
      cfg_rerr_arm = 1'b0;
      cfg_clr      = 1'b0;
      test_reset();
      test_pass();
      test_fixed();
      test_block();
      test_errors();
      test_rand();
      test_stress();
      test_reset_mid();
      test_protocol();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
